// File: rtl/decode2execute_pkg.sv
// Shared widths, ALU operation encodings and the bubble control word for the ID/EX stage.
// The optional DEID_PERF_CNT_EN build also takes its default counter width from here.
package decode2execute_pkg;

  localparam int WIDTH = 32;
  localparam int REGW  = 5;
  localparam int ALUCW = 3;
  localparam int CNTW  = 16;

  localparam logic [ALUCW-1:0] ALU_AND = 3'b000;
  localparam logic [ALUCW-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUCW-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUCW-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUCW-1:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic             regWrite;
    logic             memtoReg;
    logic             memWrite;
    logic             aluSrc;
    logic             regDst;
    logic [ALUCW-1:0] aluControl;
  } ctrl_t;

  // A bubble writes no register and no memory.
  localparam ctrl_t CTRL_BUBBLE = '{
    regWrite:   1'b0,
    memtoReg:   1'b0,
    memWrite:   1'b0,
    aluSrc:     1'b0,
    regDst:     1'b0,
    aluControl: 3'b000
  };

endpackage

// File: rtl/decode2execute_perfcnt.sv
// Bubble and stall event counters for the ID/EX stage, instantiated only when DEID_PERF_CNT_EN is defined.
// Both counters wrap modulo 2^CNTW and clear on the asynchronous active-low reset.
module decode2execute_perfcnt #(
  parameter int CNTW = decode2execute_pkg::CNTW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            bubbleLoad,
  input  logic            stallHold,
  output logic [CNTW-1:0] BubbleCnt,
  output logic [CNTW-1:0] StallCnt
);

  logic [CNTW-1:0] bubbleCnt_r;
  logic [CNTW-1:0] stallCnt_r;

  // Count bubble-loading edges and stall-only edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubbleCnt_r <= '0;
      stallCnt_r  <= '0;
    end else begin
      if (bubbleLoad) begin
        bubbleCnt_r <= bubbleCnt_r + CNTW'(1'b1);
      end
      if (stallHold) begin
        stallCnt_r <= stallCnt_r + CNTW'(1'b1);
      end
    end
  end

  assign BubbleCnt = bubbleCnt_r;
  assign StallCnt  = stallCnt_r;

endmodule

// File: rtl/decode2execute_stage.sv
// ID/EX pipeline register with flush (bubble) and stall (hold); every output is registered.
// Defining DEID_PERF_CNT_EN adds the BubbleCntE/StallCntE performance counters.
module decode2execute_stage #(
`ifdef DEID_PERF_CNT_EN
  parameter int CNTW  = decode2execute_pkg::CNTW,
`endif
  parameter int WIDTH = decode2execute_pkg::WIDTH,
  parameter int REGW  = decode2execute_pkg::REGW,
  parameter int ALUCW = decode2execute_pkg::ALUCW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             MemWriteD,
  input  logic             ALUSrcD,
  input  logic             RegDstD,
  input  logic [ALUCW-1:0] ALUControlD,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [REGW-1:0]  RsD,
  input  logic [REGW-1:0]  RtD,
  input  logic [REGW-1:0]  RdD,
  input  logic [WIDTH-1:0] SignImmD,
  output logic             RegWriteE,
  output logic             MemtoRegE,
  output logic             MemWriteE,
  output logic             ALUSrcE,
  output logic             RegDstE,
  output logic [ALUCW-1:0] ALUControlE,
  output logic [WIDTH-1:0] RD1E,
  output logic [WIDTH-1:0] RD2E,
  output logic [REGW-1:0]  RsE,
  output logic [REGW-1:0]  RtE,
  output logic [REGW-1:0]  RdE,
  output logic [WIDTH-1:0] SignImmE,
  output logic             ValidE
`ifdef DEID_PERF_CNT_EN
  ,
  output logic [CNTW-1:0]  BubbleCntE,
  output logic [CNTW-1:0]  StallCntE
`endif
);

  import decode2execute_pkg::*;

  logic             loadBubble_s;
  logic             holdStage_s;

  logic             regWrite_r;
  logic             memtoReg_r;
  logic             memWrite_r;
  logic             aluSrc_r;
  logic             regDst_r;
  logic [ALUCW-1:0] aluControl_r;
  logic [WIDTH-1:0] rd1_r;
  logic [WIDTH-1:0] rd2_r;
  logic [REGW-1:0]  rs_r;
  logic [REGW-1:0]  rt_r;
  logic [REGW-1:0]  rd_r;
  logic [WIDTH-1:0] signImm_r;
  logic             valid_r;

  // Resolve the hazard-unit request; a flush overrides a simultaneous stall.
  always_comb begin
    loadBubble_s = 1'b0;
    holdStage_s  = 1'b0;
    if (FlushE) begin
      loadBubble_s = 1'b1;
    end else if (StallE) begin
      holdStage_s = 1'b1;
    end else begin
      loadBubble_s = 1'b0;
      holdStage_s  = 1'b0;
    end
  end

  // The whole E-stage word moves together: reset, bubble, hold or load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regWrite_r   <= 1'b0;
      memtoReg_r   <= 1'b0;
      memWrite_r   <= 1'b0;
      aluSrc_r     <= 1'b0;
      regDst_r     <= 1'b0;
      aluControl_r <= '0;
      rd1_r        <= '0;
      rd2_r        <= '0;
      rs_r         <= '0;
      rt_r         <= '0;
      rd_r         <= '0;
      signImm_r    <= '0;
      valid_r      <= 1'b0;
    end else if (loadBubble_s) begin
      regWrite_r   <= CTRL_BUBBLE.regWrite;
      memtoReg_r   <= CTRL_BUBBLE.memtoReg;
      memWrite_r   <= CTRL_BUBBLE.memWrite;
      aluSrc_r     <= CTRL_BUBBLE.aluSrc;
      regDst_r     <= CTRL_BUBBLE.regDst;
      aluControl_r <= ALUCW'(CTRL_BUBBLE.aluControl);
      rd1_r        <= '0;
      rd2_r        <= '0;
      rs_r         <= '0;
      rt_r         <= '0;
      rd_r         <= '0;
      signImm_r    <= '0;
      valid_r      <= 1'b0;
    end else if (holdStage_s) begin
      regWrite_r   <= regWrite_r;
      memtoReg_r   <= memtoReg_r;
      memWrite_r   <= memWrite_r;
      aluSrc_r     <= aluSrc_r;
      regDst_r     <= regDst_r;
      aluControl_r <= aluControl_r;
      rd1_r        <= rd1_r;
      rd2_r        <= rd2_r;
      rs_r         <= rs_r;
      rt_r         <= rt_r;
      rd_r         <= rd_r;
      signImm_r    <= signImm_r;
      valid_r      <= valid_r;
    end else begin
      regWrite_r   <= RegWriteD;
      memtoReg_r   <= MemtoRegD;
      memWrite_r   <= MemWriteD;
      aluSrc_r     <= ALUSrcD;
      regDst_r     <= RegDstD;
      aluControl_r <= ALUControlD;
      rd1_r        <= RD1D;
      rd2_r        <= RD2D;
      rs_r         <= RsD;
      rt_r         <= RtD;
      rd_r         <= RdD;
      signImm_r    <= SignImmD;
      valid_r      <= 1'b1;
    end
  end

  assign RegWriteE   = regWrite_r;
  assign MemtoRegE   = memtoReg_r;
  assign MemWriteE   = memWrite_r;
  assign ALUSrcE     = aluSrc_r;
  assign RegDstE     = regDst_r;
  assign ALUControlE = aluControl_r;
  assign RD1E        = rd1_r;
  assign RD2E        = rd2_r;
  assign RsE         = rs_r;
  assign RtE         = rt_r;
  assign RdE         = rd_r;
  assign SignImmE    = signImm_r;
  assign ValidE      = valid_r;

`ifdef DEID_PERF_CNT_EN
  decode2execute_perfcnt #(
    .CNTW(CNTW)
  ) u_perfcnt (
    .clk       (clk),
    .reset     (reset),
    .bubbleLoad(loadBubble_s),
    .stallHold (holdStage_s),
    .BubbleCnt (BubbleCntE),
    .StallCnt  (StallCntE)
  );
`endif

endmodule

// File: tb/tb_decode2execute_stage.sv
// Self-checking bench for decode2execute_stage: directed scenarios plus randomized traffic
// against a whole-word reference model; counter checks run when DEID_PERF_CNT_EN is defined.
module tb_decode2execute_stage;
  import decode2execute_pkg::*;

  localparam int W    = 32;
  localparam int RW   = 5;
  localparam int AW   = 3;
  localparam int OBSW = 5 + AW + 3 * W + 3 * RW + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic StallE = 1'b0, FlushE = 1'b0;
  logic RegWriteD = 1'b0, MemtoRegD = 1'b0, MemWriteD = 1'b0, ALUSrcD = 1'b0, RegDstD = 1'b0;
  logic [AW-1:0] ALUControlD = '0;
  logic [W-1:0]  RD1D = '0, RD2D = '0, SignImmD = '0;
  logic [RW-1:0] RsD = '0, RtD = '0, RdD = '0;
  logic RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ValidE;
  logic [AW-1:0] ALUControlE;
  logic [W-1:0]  RD1E, RD2E, SignImmE;
  logic [RW-1:0] RsE, RtE, RdE;

  int errors = 0;
  int checks = 0;
  logic [OBSW-1:0] expVec = '0;
  int modelBubbles = 0;
  int modelStalls  = 0;

  always #5 clk = ~clk;

  decode2execute_stage dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .RsD(RsD), .RtD(RtD), .RdD(RdD), .SignImmD(SignImmD),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .RsE(RsE), .RtE(RtE), .RdE(RdE), .SignImmE(SignImmE),
    .ValidE(ValidE)
`ifdef DEID_PERF_CNT_EN
    ,
    .BubbleCntE(BubbleCntE), .StallCntE(StallCntE)
`endif
  );

`ifdef DEID_PERF_CNT_EN
  logic [15:0] BubbleCntE, StallCntE;
  logic [1:0]  smallBubble, smallStall;
  logic        sRegWriteE, sMemtoRegE, sMemWriteE, sALUSrcE, sRegDstE, sValidE;
  logic [AW-1:0] sALUControlE;
  logic [W-1:0]  sRD1E, sRD2E, sSignImmE;
  logic [RW-1:0] sRsE, sRtE, sRdE;

  decode2execute_stage #(.CNTW(2)) dutSmall (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .RsD(RsD), .RtD(RtD), .RdD(RdD), .SignImmD(SignImmD),
    .RegWriteE(sRegWriteE), .MemtoRegE(sMemtoRegE), .MemWriteE(sMemWriteE),
    .ALUSrcE(sALUSrcE), .RegDstE(sRegDstE), .ALUControlE(sALUControlE),
    .RD1E(sRD1E), .RD2E(sRD2E), .RsE(sRsE), .RtE(sRtE), .RdE(sRdE), .SignImmE(sSignImmE),
    .ValidE(sValidE), .BubbleCntE(smallBubble), .StallCntE(smallStall)
  );
`endif

  wire [OBSW-1:0] obsVec = {RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
                            RD1E, RD2E, RsE, RtE, RdE, SignImmE, ValidE};
  wire [OBSW-1:0] inVec  = {RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD,
                            RD1D, RD2D, RsD, RtD, RdD, SignImmD, 1'b1};

  // Reference: a real edge either empties the stage, keeps it, or copies the D word in.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      if (FlushE) begin
        expVec = '0;
        modelBubbles++;
      end else if (StallE) begin
        modelStalls++;
      end else begin
        expVec = inVec;
      end
    end
    @(negedge clk);
  endtask

  task automatic randomizeD();
    {RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD} = 5'($urandom);
    ALUControlD = 3'($urandom);
    RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom;
    RsD = 5'($urandom); RtD = 5'($urandom); RdD = 5'($urandom);
  endtask

  task automatic applyReset();
    reset = 1'b0;
    expVec = '0;
    modelBubbles = 0;
    modelStalls = 0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    expVec = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obsVec !== '0) begin errors++; $display("FAIL reset_state obs=%h exp=0", obsVec); end
    reset = 1'b1;
    randomizeD();
    RegWriteD = 1'b1;
    tick();
    checks++;
    if (obsVec !== expVec) begin errors++; $display("FAIL first_load obs=%h exp=%h", obsVec, expVec); end
    checks++;
    if (RegWriteE !== 1'b1) begin errors++; $display("FAIL pre_reset_regwrite obs=%b exp=1", RegWriteE); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obsVec !== '0 || clk !== 1'b0) begin
      errors++; $display("FAIL async_reset obs=%h clk=%b exp=0 before edge", obsVec, clk);
    end
    expVec = '0;
    modelBubbles = 0;
    modelStalls = 0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_load();
    randomizeD();
    RD1D = 32'h0000_1234; RtD = 5'd9; RegWriteD = 1'b1; MemWriteD = 1'b0; ALUControlD = ALU_ADD;
    tick();
    checks++;
    if (RD1E !== 32'h0000_1234 || RtE !== 5'd9 || RegWriteE !== 1'b1 || MemWriteE !== 1'b0 || ValidE !== 1'b1)
    begin
      errors++;
      $display("FAIL load RD1E=%h RtE=%0d RegWriteE=%b MemWriteE=%b ValidE=%b exp 1234/9/1/0/1",
               RD1E, RtE, RegWriteE, MemWriteE, ValidE);
    end
    checks++;
    if (obsVec !== expVec) begin errors++; $display("FAIL load_word obs=%h exp=%h", obsVec, expVec); end
  endtask

  task automatic test_stall();
    randomizeD();
    SignImmD = 32'hFFFF_FFF0;
    tick();
    StallE = 1'b1;
    randomizeD();
    SignImmD = 32'h0000_0005;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (SignImmE !== 32'hFFFF_FFF0 || ValidE !== 1'b1) begin
        errors++; $display("FAIL stall_hold cyc=%0d SignImmE=%h ValidE=%b exp fffffff0/1", i, SignImmE, ValidE);
      end
    end
    StallE = 1'b0;
    tick();
    checks++;
    if (SignImmE !== 32'h0000_0005) begin errors++; $display("FAIL stall_release SignImmE=%h exp 5", SignImmE); end
    checks++;
    if (obsVec !== expVec) begin errors++; $display("FAIL stall_word obs=%h exp=%h", obsVec, expVec); end
  endtask

  task automatic test_flush();
    randomizeD();
    MemWriteD = 1'b1; RegWriteD = 1'b1;
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    checks++;
    if (MemWriteE !== 1'b0 || RegWriteE !== 1'b0 || ValidE !== 1'b0 || {RD1E, RD2E, SignImmE} !== '0) begin
      errors++;
      $display("FAIL flush MemWriteE=%b RegWriteE=%b ValidE=%b data=%h exp all 0",
               MemWriteE, RegWriteE, ValidE, {RD1E, RD2E, SignImmE});
    end
    checks++;
    if (obsVec !== '0) begin errors++; $display("FAIL flush_word obs=%h exp=0", obsVec); end
  endtask

  task automatic test_simultaneous();
    randomizeD();
    MemtoRegD = 1'b1;
    tick();
    FlushE = 1'b1; StallE = 1'b1;
    tick();
    FlushE = 1'b0; StallE = 1'b0;
    checks++;
    if (MemtoRegE !== 1'b0 || ValidE !== 1'b0) begin
      errors++; $display("FAIL flush_over_stall MemtoRegE=%b ValidE=%b exp 0/0", MemtoRegE, ValidE);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      randomizeD();
      StallE = ($urandom_range(0, 3) == 0);
      FlushE = ($urandom_range(0, 5) == 0);
      tick();
      checks++;
      if (obsVec !== expVec) begin errors++; $display("FAIL random cyc=%0d obs=%h exp=%h", i, obsVec, expVec); end
`ifdef DEID_PERF_CNT_EN
      checks++;
      if (BubbleCntE !== 16'(modelBubbles) || StallCntE !== 16'(modelStalls)) begin
        errors++; $display("FAIL random_cnt cyc=%0d bub=%0d stl=%0d exp %0d/%0d",
                           i, BubbleCntE, StallCntE, 16'(modelBubbles), 16'(modelStalls));
      end
`endif
    end
    StallE = 1'b0;
    FlushE = 1'b0;
  endtask

`ifdef DEID_PERF_CNT_EN
  task automatic test_counters();
    applyReset();
    checks++;
    if (BubbleCntE !== 16'd0 || StallCntE !== 16'd0) begin
      errors++; $display("FAIL cnt_reset bub=%0d stl=%0d exp 0/0", BubbleCntE, StallCntE);
    end
    for (int i = 0; i < 4; i++) begin FlushE = 1'b1; tick(); end
    FlushE = 1'b0;
    for (int i = 0; i < 2; i++) begin StallE = 1'b1; tick(); end
    StallE = 1'b0;
    tick();
    checks++;
    if (BubbleCntE !== 16'd4 || StallCntE !== 16'd2) begin
      errors++; $display("FAIL cnt_basic bub=%0d stl=%0d exp 4/2", BubbleCntE, StallCntE);
    end
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    checks++;
    if (smallBubble !== 2'd1 || smallStall !== 2'd2) begin
      errors++; $display("FAIL cnt_wrap bub=%0d stl=%0d exp 1/2", smallBubble, smallStall);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_simultaneous();
    test_random();
`ifdef DEID_PERF_CNT_EN
    test_counters();
`endif
    applyReset();
    checks++;
    if (obsVec !== expVec) begin errors++; $display("FAIL final_reset obs=%h exp=%h", obsVec, expVec); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
